ft_stream_ctrl: RTL
===================

Name: ft_stream_ctrl

Overview:
- Host-side streaming controller between the camera pixel FIFO and the FT232H synchronous-FIFO byte interface.
- Decodes one-byte host commands and answers a configuration query.
- Streams captured lines as framed packets; each packet carries an ID/flags byte and a 16-bit line index ahead of the payload.
- Generalised over bytes-per-pixel and adds single-frame snapshot, packet-boundary stop and a sticky overflow status.

Parameters:
- IM_X, 640, pixels per line (1..65535).
- IM_Y, 480, lines per frame (1..65535).
- BPP, 2, bytes per pixel (1..4).
- LINE_BYTES, IM_X*BPP, payload bytes per packet (derived localparam).
- CW, $clog2(2*LINE_BYTES+1), width of fifo_usedw and byte counters (derived localparam).

Ports:
- clk  in  1  system/FT clock
- rst_n  in  1  async reset, active-low
- stream_en  out  1  capture enable; low holds the capture path and pixel FIFO in reset
- fifo_empty  in  1  pixel FIFO empty
- fifo_rdata  in  8  show-ahead head byte of pixel FIFO
- fifo_usedw  in  CW  bytes in pixel FIFO
- fifo_ovf  in  1  single-cycle pulse: capture side dropped a byte (FIFO full)
- fifo_rd  out  1  pop pixel FIFO (combinational)
- rd_ready  in  1  host byte available (FT RXF active)
- read  out  1  one-cycle host-byte read request
- data_valid  in  1  read_data valid
- read_data  in  8  host command byte
- wr_ready  in  1  FT TX FIFO can accept a byte
- write  out  1  write strobe (valid)
- write_data  out  8  byte to host

Behaviour:
- Reset: write, read, fifo_rd, stream_en = 0; write_data = 0; all counters 0; mode bits and overflow flag cleared. Reset mid-packet aborts without completing the packet.
- Write handshake: a byte transfers on any clk edge with write=1 and wr_ready=1. While write=1 and wr_ready=0, write and write_data hold unchanged. No byte is ever dropped or duplicated.
- Commands:
  - 0x01 GET_CFG.
  - 0x11 START (continuous).
  - 0x12 SNAP (one frame).
  - 0x0F STOP.
  - Any other byte is ignored.
- Command read: in IDLE or WAIT with rd_ready=1, pulse read for 1 cycle, go to CMD. CMD waits for data_valid and decodes read_data. Return state: IDLE if not streaming, WAIT if streaming.
- FSM states: IDLE, CMD, CFG, WAIT, HDR, PAY.
- CFG:
  - Sends 7 bytes in order: 0x5A, IM_X[7:0], IM_X[15:8], IM_Y[7:0], IM_Y[15:8], BPP, status.
  - status = {5'b0, ovf_flag, snap_mode, stream_en}.
  - After the last byte is accepted: return to IDLE, or to WAIT if streaming.
  - GET_CFG is legal while streaming; it is accepted only in WAIT, i.e. between packets.
- START/SNAP:
  - Set stream_en=1 and set mode (snap_mode=1 for SNAP).
  - Clear line_cnt and ovf_flag; go to WAIT.
  - START or SNAP while already streaming only updates snap_mode.
- WAIT:
  - Pending host commands take priority over a packet start.
  - Otherwise, if fifo_usedw >= LINE_BYTES, go to HDR.
- HDR: 3 bytes.
  - Byte 0: ID = {4'hA, sof, BPP-1[2:0]}, where sof=1 when line_cnt==0.
  - Byte 1: line_cnt[7:0]. Byte 2: line_cnt[15:8].
- PAY:
  - Sends exactly LINE_BYTES bytes from fifo_rdata.
  - fifo_rd = (state==PAY) & write-slot free & !fifo_empty & bytes_loaded < LINE_BYTES. This pops concurrently with loading write_data.
  - fifo_empty mid-packet inserts bubbles only (write=0), never short packets.
- End of packet (last payload byte accepted):
  - line_cnt increments; wraps to 0 at IM_Y.
  - Wrap with snap_mode=1: stream_en <= 0, go to IDLE.
  - Otherwise go to WAIT.
- STOP:
  - Decoded only in CMD, so it always takes effect at a packet boundary.
  - Sets stream_en=0 and goes to IDLE.
  - STOP in IDLE is a no-op.
- Overflow: fifo_ovf sets a sticky ovf_flag. It is cleared only by START/SNAP or reset. Streaming continues.
- Simultaneous rd_ready and FIFO ready in WAIT: command first.

Test Plan:
1. IM_X=4, IM_Y=2, BPP=2; host sends 0x01 -> 7 bytes out: 5A 04 00 02 00 02 00; returns to IDLE; stream_en stays 0.
2. 0x12 SNAP, feed 16 bytes 0x00..0x0F -> packets:
   - First packet: A9 00 00 00..07.
   - Second packet: A1 01 00 08..0F.
   - Then stream_en=0 and IDLE; no further writes.
3. Same stimulus, wr_ready toggled low for 3 cycles mid-payload -> write/write_data hold; host sees an identical byte sequence; total 22 bytes.
4. 0x11 START, 3 frames fed -> sof bit set only on packets with line 0; line field sequence 0,1,0,1,0,1.
5. 0x0F issued during a payload byte 3 -> current packet completes all 11 bytes, then stream_en=0; no new HDR byte.
6. Pulse fifo_ovf during streaming, then GET_CFG in WAIT -> last cfg byte = 0x07. After a new START, GET_CFG returns 0x01.

Source files
------------

// File: rtl/ft_stream_ctrl_if.sv
// Handshake bundle between the streaming controller, the pixel FIFO and the
// FT232H synchronous-FIFO port. master = controller side, slave = environment.
interface ft_stream_ctrl_if #(
  parameter int CW = 5
);
  logic          stream_en;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_usedw;
  logic          fifo_ovf;
  logic          fifo_rd;
  logic          rd_ready;
  logic          read;
  logic          data_valid;
  logic [7:0]    read_data;
  logic          wr_ready;
  logic          write;
  logic [7:0]    write_data;

  modport master (
    output stream_en, fifo_rd, read, write, write_data,
    input  fifo_empty, fifo_rdata, fifo_usedw, fifo_ovf,
           rd_ready, data_valid, read_data, wr_ready
  );

  modport slave (
    input  stream_en, fifo_rd, read, write, write_data,
    output fifo_empty, fifo_rdata, fifo_usedw, fifo_ovf,
           rd_ready, data_valid, read_data, wr_ready
  );
endinterface

// File: rtl/ft_stream_ctrl.sv
// Host-side streaming controller: decodes one-byte host commands, answers the
// configuration query and streams camera lines as framed packets to the FT232H.
module ft_stream_ctrl #(
  parameter int IM_X = 640,
  parameter int IM_Y = 480,
  parameter int BPP  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ft_stream_ctrl_if.master    bus
);
  localparam int LINE_BYTES = IM_X * BPP;
  localparam int CW         = $clog2(2 * LINE_BYTES + 1);

  localparam logic [15:0]   IM_X_W       = 16'(IM_X);
  localparam logic [15:0]   IM_Y_W       = 16'(IM_Y);
  localparam logic [15:0]   LAST_LINE    = 16'(IM_Y - 1);
  localparam logic [7:0]    BPP_W        = 8'(BPP);
  localparam logic [2:0]    BPP_ID       = 3'(BPP - 1);
  localparam logic [CW-1:0] LINE_BYTES_W = CW'(LINE_BYTES);

  typedef enum logic [2:0] {IDLE, CMD, CFG, WAIT, HDR, PAY} state_e;

  state_e        state_q, state_d;
  logic          stream_en_q, stream_en_d;
  logic          snap_q, snap_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   line_q, line_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] loaded_q, loaded_d;
  logic          write_q, write_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          read_q, read_d;

  logic          slot_free;
  logic          pop;
  logic [7:0]    status;
  logic [7:0]    cfg_byte;
  logic [7:0]    hdr_byte;
  state_e        ret_state;

  // The output register is free when empty or when its byte leaves on this edge.
  assign slot_free = !write_q || bus.wr_ready;
  assign pop       = (state_q == PAY) && slot_free && !bus.fifo_empty &&
                     (loaded_q < LINE_BYTES_W);
  assign status    = {5'b0, ovf_q, snap_q, stream_en_q};
  assign ret_state = stream_en_q ? WAIT : IDLE;

  always_comb begin
    cfg_byte = 8'h00;
    case (idx_q)
      3'd0:    cfg_byte = 8'h5A;
      3'd1:    cfg_byte = IM_X_W[7:0];
      3'd2:    cfg_byte = IM_X_W[15:8];
      3'd3:    cfg_byte = IM_Y_W[7:0];
      3'd4:    cfg_byte = IM_Y_W[15:8];
      3'd5:    cfg_byte = BPP_W;
      3'd6:    cfg_byte = status;
      default: cfg_byte = 8'h00;
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q)
      3'd0:    hdr_byte = {4'hA, (line_q == 16'd0), BPP_ID};
      3'd1:    hdr_byte = line_q[7:0];
      default: hdr_byte = line_q[15:8];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stream_en_d = stream_en_q;
    snap_d      = snap_q;
    ovf_d       = ovf_q;
    line_d      = line_q;
    idx_d       = idx_q;
    loaded_d    = loaded_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    read_d      = 1'b0;
    if (slot_free) write_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rd_ready) begin
          read_d  = 1'b1;
          state_d = CMD;
        end
      end
      WAIT: begin
        if (bus.rd_ready) begin
          read_d  = 1'b1;
          state_d = CMD;
        end else if (bus.fifo_usedw >= LINE_BYTES_W) begin
          idx_d   = 3'd0;
          state_d = HDR;
        end
      end
      CMD: begin
        if (bus.data_valid) begin
          state_d = ret_state;
          case (bus.read_data)
            8'h01: begin
              idx_d   = 3'd0;
              state_d = CFG;
            end
            8'h11, 8'h12: begin
              snap_d  = (bus.read_data == 8'h12);
              state_d = WAIT;
              if (!stream_en_q) begin
                stream_en_d = 1'b1;
                line_d      = 16'd0;
                ovf_d       = 1'b0;
              end
            end
            8'h0F: begin
              stream_en_d = 1'b0;
              state_d     = IDLE;
            end
            default: ;
          endcase
        end
      end
      CFG: begin
        if (slot_free) begin
          if (idx_q == 3'd7) begin
            state_d = ret_state;
          end else begin
            write_d = 1'b1;
            wdata_d = cfg_byte;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      HDR: begin
        if (slot_free) begin
          write_d = 1'b1;
          wdata_d = hdr_byte;
          if (idx_q == 3'd2) begin
            loaded_d = '0;
            state_d  = PAY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PAY: begin
        if (pop) begin
          write_d  = 1'b1;
          wdata_d  = bus.fifo_rdata;
          loaded_d = loaded_q + CW'(1);
        end else if (slot_free && (loaded_q == LINE_BYTES_W)) begin
          // Last payload byte has been accepted: close the packet.
          loaded_d = '0;
          state_d  = WAIT;
          if (line_q == LAST_LINE) begin
            line_d = 16'd0;
            if (snap_q) begin
              stream_en_d = 1'b0;
              state_d     = IDLE;
            end
          end else begin
            line_d = line_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.fifo_ovf) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stream_en_q <= 1'b0;
      snap_q      <= 1'b0;
      ovf_q       <= 1'b0;
      line_q      <= 16'd0;
      idx_q       <= 3'd0;
      loaded_q    <= '0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      read_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stream_en_q <= stream_en_d;
      snap_q      <= snap_d;
      ovf_q       <= ovf_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      loaded_q    <= loaded_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      read_q      <= read_d;
    end
  end

  assign bus.stream_en  = stream_en_q;
  assign bus.fifo_rd    = pop;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.write_data = wdata_q;
endmodule
